// File: rtl/jtdd_gfx_arb.sv
// jtdd_gfx_arb: round-robin arbiter sharing one SDRAM read port between the
// char, scroll and object graphics ROM requesters. Each requester has a
// one-word cache; an SDRAM read is issued only when its address misses.
module jtdd_gfx_arb #(
  parameter int            AW          = 22,
  parameter logic [AW-1:0] CHAR_OFFSET = 22'h00000,
  parameter logic [AW-1:0] SCR_OFFSET  = 22'h08000,
  parameter logic [AW-1:0] OBJ_OFFSET  = 22'h28000
) (
  input  logic          clk,
  input  logic          rst,
  // char requester (byte addressed)
  input  logic          char_cs,
  input  logic [15:0]   char_addr,
  output logic [7:0]    char_data,
  output logic          char_ok,
  // scroll requester
  input  logic          scr_cs,
  input  logic [16:0]   scr_addr,
  output logic [15:0]   scr_data,
  output logic          scr_ok,
  // object requester
  input  logic          obj_cs,
  input  logic [18:0]   obj_addr,
  output logic [15:0]   obj_data,
  output logic          obj_ok,
  // SDRAM read port
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [15:0]   data_read
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SLOT_CHAR = 2'd0,
    SLOT_SCR  = 2'd1,
    SLOT_OBJ  = 2'd2
  } slot_t;

  state_t        state, state_nx;
  slot_t         last;      // last slot granted, round-robin origin
  slot_t         cur;       // slot owning the transfer in flight
  slot_t         gnt_slot;
  logic          gnt_any;
  logic [AW-1:0] gnt_addr;
  logic          do_grant;
  logic          do_fill;

  // per-slot cache
  logic [14:0]   char_lat;
  logic [16:0]   scr_lat;
  logic [18:0]   obj_lat;
  logic [15:0]   char_word;
  logic [15:0]   scr_word;
  logic [15:0]   obj_word;
  logic [2:0]    valid;

  logic [14:0]   char_waddr;
  logic [2:0]    hit;
  logic [2:0]    pend;

  assign char_waddr = char_addr[15:1];

  // Cache hit detection against the live addresses
  always_comb begin
    hit[SLOT_CHAR] = valid[SLOT_CHAR] & (char_waddr == char_lat);
    hit[SLOT_SCR]  = valid[SLOT_SCR]  & (scr_addr   == scr_lat);
    hit[SLOT_OBJ]  = valid[SLOT_OBJ]  & (obj_addr   == obj_lat);
    pend           = {obj_cs, scr_cs, char_cs} & ~hit;
  end

  assign char_ok   = char_cs & hit[SLOT_CHAR];
  assign scr_ok    = scr_cs  & hit[SLOT_SCR];
  assign obj_ok    = obj_cs  & hit[SLOT_OBJ];

  // byte select follows the live address so both bytes of a word hit
  assign char_data = char_addr[0] ? char_word[15:8] : char_word[7:0];
  assign scr_data  = scr_word;
  assign obj_data  = obj_word;

  // Round-robin pick: search starts at the slot after the last grant.
  // Falling back to the last slot itself is only reached when it is the
  // sole pending one, since gnt_any gates every use of gnt_slot.
  always_comb begin
    gnt_any  = |pend;
    gnt_slot = SLOT_CHAR;
    case (last)
      SLOT_CHAR: begin
        if (pend[SLOT_SCR])       gnt_slot = SLOT_SCR;
        else if (pend[SLOT_OBJ])  gnt_slot = SLOT_OBJ;
        else                      gnt_slot = SLOT_CHAR;
      end
      SLOT_SCR: begin
        if (pend[SLOT_OBJ])       gnt_slot = SLOT_OBJ;
        else if (pend[SLOT_CHAR]) gnt_slot = SLOT_CHAR;
        else                      gnt_slot = SLOT_SCR;
      end
      default: begin
        if (pend[SLOT_CHAR])      gnt_slot = SLOT_CHAR;
        else if (pend[SLOT_SCR])  gnt_slot = SLOT_SCR;
        else                      gnt_slot = SLOT_OBJ;
      end
    endcase
  end

  // SDRAM address of the slot about to be granted
  always_comb begin
    gnt_addr = CHAR_OFFSET + AW'(char_waddr);
    case (gnt_slot)
      SLOT_SCR: gnt_addr = SCR_OFFSET + AW'(scr_addr);
      SLOT_OBJ: gnt_addr = OBJ_OFFSET + AW'(obj_addr);
      default:  gnt_addr = CHAR_OFFSET + AW'(char_waddr);
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state and transfer strobes
  always_comb begin
    state_nx = state;
    do_grant = 1'b0;
    do_fill  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          do_grant = 1'b1;
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) state_nx = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (data_rdy) begin
          do_fill  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request registers, round-robin pointer and per-slot cache updates
  always_ff @(posedge clk) begin
    if (rst) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      last       <= SLOT_OBJ;
      cur        <= SLOT_CHAR;
      valid      <= '0;
      char_lat   <= '0;
      scr_lat    <= '0;
      obj_lat    <= '0;
      char_word  <= '0;
      scr_word   <= '0;
      obj_word   <= '0;
    end else begin
      if (do_grant) begin
        sdram_req       <= 1'b1;
        sdram_addr      <= gnt_addr;
        last            <= gnt_slot;
        cur             <= gnt_slot;
        valid[gnt_slot] <= 1'b0;
        case (gnt_slot)
          SLOT_SCR: scr_lat  <= scr_addr;
          SLOT_OBJ: obj_lat  <= obj_addr;
          default:  char_lat <= char_waddr;
        endcase
      end
      if (state == WAIT_ACK && sdram_ack) sdram_req <= 1'b0;
      // the fill lands in the slot latched at grant time even if that
      // slot's address has moved on; the stale lat_addr keeps it missing
      if (do_fill) begin
        valid[cur] <= 1'b1;
        case (cur)
          SLOT_SCR: scr_word  <= data_read;
          SLOT_OBJ: obj_word  <= data_read;
          default:  char_word <= data_read;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtdd_gfx_arb.sv
// Scoreboard bench for jtdd_gfx_arb: expected SDRAM addresses and expected
// ok/data results are queued by the stimulus; a monitor compares them when
// sdram_req or an ok flag rises.
module tb_jtdd_gfx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        char_cs, scr_cs, obj_cs;
  logic [15:0] char_addr;
  logic [16:0] scr_addr;
  logic [18:0] obj_addr;
  logic [7:0]  char_data;
  logic [15:0] scr_data, obj_data;
  logic        char_ok, scr_ok, obj_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack, data_rdy;
  logic [15:0] data_read;

  int n_cmp = 0;
  int n_bad = 0;

  logic [21:0] exp_addr[$];
  logic [7:0]  exp_char[$];
  logic [15:0] exp_scr[$];
  logic [15:0] exp_obj[$];

  always #5 clk = ~clk;

  jtdd_gfx_arb #(
    .AW(22),
    .CHAR_OFFSET(22'h00000),
    .SCR_OFFSET(22'h08000),
    .OBJ_OFFSET(22'h28000)
  ) dut (
    .clk(clk), .rst(rst),
    .char_cs(char_cs), .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int t = 0;
    while (!sdram_req && t < 100) begin
      step();
      t++;
    end
    check("req_timeout", {31'd0, sdram_req}, 32'd1);
  endtask

  task automatic serve_ack(input int dly);
    wait_req();
    repeat (dly) step();
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
  endtask

  task automatic serve_data(input int dly, input logic [15:0] d);
    repeat (dly) step();
    data_rdy  = 1'b1;
    data_read = d;
    step();
    data_rdy  = 1'b0;
    data_read = '0;
  endtask

  // Monitor: compare queued expectations on rising req / ok
  initial begin
    logic rq, cq, sq, oq;
    rq = 1'b0; cq = 1'b0; sq = 1'b0; oq = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sdram_req && !rq) begin
          if (exp_addr.size() == 0) check("extra_req", 32'd1, 32'd0);
          else check("sdram_addr", {10'd0, sdram_addr}, {10'd0, exp_addr.pop_front()});
        end
        if (char_ok && !cq) begin
          if (exp_char.size() == 0) check("extra_char_ok", 32'd1, 32'd0);
          else check("char_data", {24'd0, char_data}, {24'd0, exp_char.pop_front()});
        end
        if (scr_ok && !sq) begin
          if (exp_scr.size() == 0) check("extra_scr_ok", 32'd1, 32'd0);
          else check("scr_data", {16'd0, scr_data}, {16'd0, exp_scr.pop_front()});
        end
        if (obj_ok && !oq) begin
          if (exp_obj.size() == 0) check("extra_obj_ok", 32'd1, 32'd0);
          else check("obj_data", {16'd0, obj_data}, {16'd0, exp_obj.pop_front()});
        end
      end
      rq = sdram_req; cq = char_ok; sq = scr_ok; oq = obj_ok;
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    rst = 1'b1;
    char_cs = 1'b1; scr_cs = 1'b1; obj_cs = 1'b1;
    char_addr = 16'h0040; scr_addr = 17'h00010; obj_addr = 19'h00100;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    repeat (3) step();
    @(negedge clk);
    check("rst_char_ok", {31'd0, char_ok}, 32'd0);
    check("rst_scr_ok", {31'd0, scr_ok}, 32'd0);
    check("rst_obj_ok", {31'd0, obj_ok}, 32'd0);
    check("rst_req", {31'd0, sdram_req}, 32'd0);
    check("rst_addr", {10'd0, sdram_addr}, 32'd0);
    check("rst_data", {8'd0, char_data, scr_data ^ obj_data}, 32'd0);
    check("rst_scr_data", {16'd0, scr_data}, 32'd0);

    // all three miss together: char, scr, obj
    exp_addr.push_back(22'h000020);
    exp_addr.push_back(22'h008010);
    exp_addr.push_back(22'h028100);
    step();
    rst = 1'b0;
    exp_char.push_back(8'hA5);
    serve_ack(1); serve_data(1, 16'h12A5);
    @(negedge clk);
    check("char_ok_fill", {31'd0, char_ok}, 32'd1);
    exp_scr.push_back(16'hBEEF);
    serve_ack(2); serve_data(3, 16'hBEEF);
    @(negedge clk);
    check("scr_ok_next", {31'd0, scr_ok}, 32'd1);
    check("scr_data_beef", {16'd0, scr_data}, 32'h0000BEEF);
    exp_obj.push_back(16'h0B01);
    serve_ack(0); serve_data(0, 16'h0B01);

    // byte select within the cached char word
    step();
    char_addr = 16'h0041;
    @(negedge clk);
    check("char_hi_byte", {24'd0, char_data}, 32'h12);
    check("char_ok_held", {31'd0, char_ok}, 32'd1);
    repeat (4) step();
    @(negedge clk);
    check("no_req_byte", {31'd0, sdram_req}, 32'd0);

    // cs low leaves arbitration but keeps the cache
    step();
    obj_cs = 1'b0;
    @(negedge clk);
    check("obj_ok_cs0", {31'd0, obj_ok}, 32'd0);
    step();
    obj_addr = 19'h00300;
    repeat (3) step();
    @(negedge clk);
    check("no_req_cs0", {31'd0, sdram_req}, 32'd0);
    step();
    obj_addr = 19'h00100;
    exp_obj.push_back(16'h0B01);
    obj_cs = 1'b1;
    @(negedge clk);
    check("obj_ok_recs", {31'd0, obj_ok}, 32'd1);

    // char-only refill so that last = char
    step();
    exp_addr.push_back(22'h000080);
    exp_char.push_back(8'h56);
    char_addr = 16'h0100;
    serve_ack(1); serve_data(1, 16'h3456);

    // scr, obj, char miss together after a char grant
    step();
    exp_addr.push_back(22'h008011);
    exp_addr.push_back(22'h028101);
    exp_addr.push_back(22'h000081);
    scr_addr = 17'h00011;
    char_addr = 16'h0102;
    obj_addr = 19'h00101;
    @(negedge clk);
    check("scr_ok_drop", {31'd0, scr_ok}, 32'd0);
    check("char_ok_drop", {31'd0, char_ok}, 32'd0);
    check("obj_ok_drop", {31'd0, obj_ok}, 32'd0);
    exp_scr.push_back(16'h5511);
    serve_ack(1); serve_data(1, 16'h5511);
    exp_obj.push_back(16'h7701);
    serve_ack(1); serve_data(1, 16'h7701);
    exp_char.push_back(8'h21);
    serve_ack(1); serve_data(1, 16'h9A21);

    // object address change while its read is in flight
    step();
    exp_addr.push_back(22'h028100);
    obj_addr = 19'h00100;
    serve_ack(1);
    step();
    obj_addr = 19'h00200;
    exp_addr.push_back(22'h028200);
    serve_data(1, 16'hDEAD);
    @(negedge clk);
    check("obj_ok_stale", {31'd0, obj_ok}, 32'd0);
    exp_obj.push_back(16'hC200);
    serve_ack(1); serve_data(1, 16'hC200);
    @(negedge clk);
    check("obj_ok_refill", {31'd0, obj_ok}, 32'd1);

    // reset in WAIT_DATA, then a late data_rdy
    step();
    exp_addr.push_back(22'h008020);
    scr_addr = 17'h00020;
    serve_ack(1);
    step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    exp_addr.push_back(22'h000081);
    exp_addr.push_back(22'h008020);
    exp_addr.push_back(22'h028200);
    data_rdy = 1'b1;
    data_read = 16'hFFFF;
    step();
    step();
    data_rdy = 1'b0;
    data_read = '0;
    @(negedge clk);
    check("post_rst_char_ok", {31'd0, char_ok}, 32'd0);
    check("post_rst_scr_ok", {31'd0, scr_ok}, 32'd0);
    check("post_rst_obj_ok", {31'd0, obj_ok}, 32'd0);
    check("post_rst_scr_data", {16'd0, scr_data}, 32'd0);
    exp_char.push_back(8'h81);
    serve_ack(1); serve_data(1, 16'h7781);
    exp_scr.push_back(16'h2020);
    serve_ack(1); serve_data(1, 16'h2020);
    exp_obj.push_back(16'h0222);
    serve_ack(1); serve_data(1, 16'h0222);

    repeat (5) step();
    check("addr_q_empty", exp_addr.size(), 32'd0);
    check("char_q_empty", exp_char.size(), 32'd0);
    check("scr_q_empty", exp_scr.size(), 32'd0);
    check("obj_q_empty", exp_obj.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
